// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, access sizes, FSM encodings
// and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } lsu_size_e;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StRmwWr = 1'b1;

  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SizeByte;
      2'b01:   return SizeHalf;
      default: return SizeWord;
    endcase
  endfunction

  function automatic logic f3_load_ok(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic f3_store_ok(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: merges sub-word store data into a word and extracts/extends
// sub-word load data from a word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  lsu_size_e   size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    unique case (offset)
      2'd0: ld_byte = word[7:0];
      2'd1: ld_byte = word[15:8];
      2'd2: ld_byte = word[23:16];
      default: ld_byte = word[31:24];
    endcase
    // Halfword lanes use addr[1] only, so an odd half address aligns down.
    ld_half = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = word;
    case (size)
      SizeByte: load_data = is_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SizeHalf: load_data = is_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:  load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SizeByte: begin
        unique case (offset)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SizeHalf: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide data memory: byte->word addressing, sub-word load
// extension, SB/SH via a 2-cycle read-modify-write. Option macro: LSU_MISALIGN_EXC_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORD_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  ld_valid,
  output logic [DATA_WIDTH-1:0] ld_data,
`ifdef LSU_MISALIGN_EXC_EN
  output logic                  misalign_exc,
`endif
  output logic                  mem_re,
  output logic [31:0]           mem_r_address,
  output logic                  mem_we,
  output logic [31:0]           mem_w_address,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  logic [0:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  rmw_data_q, rmw_data_d;
  logic [WORD_ADDR_W-1:0] rmw_idx_q, rmw_idx_d;
  logic                   ld_valid_d;
  logic [DATA_WIDTH-1:0]  ld_data_d;

  logic [WORD_ADDR_W-1:0] idx, w_idx;
  logic                   active, ld_ok, st_ok, misaligned;
  lsu_size_e              size;
  logic [DATA_WIDTH-1:0]  lane_merged, lane_load;
  logic                   unused_addr_bits;

  assign idx              = req_addr[WORD_ADDR_W+1:2];
  assign unused_addr_bits = ^req_addr[31:WORD_ADDR_W+2];
  assign size             = f3_size(req_funct3);
  // Reset also silences the combinational outputs so nothing reaches memory while held.
  assign active           = rst_n && req_valid && (state_q == StIdle);
  assign ld_ok            = !req_we && f3_load_ok(req_funct3);
  assign st_ok            = req_we && f3_store_ok(req_funct3);

`ifdef LSU_MISALIGN_EXC_EN
  logic exc_d;

  assign misaligned = ((size == SizeHalf) && req_addr[0]) ||
                      ((size == SizeWord) && (req_addr[1:0] != 2'b00));
  assign exc_d      = active && (ld_ok || st_ok) && misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_exc <= 1'b0;
    else        misalign_exc <= exc_d;
  end
`else
  assign misaligned = 1'b0;
`endif

  lsu_byte_lane u_byte_lane (
    .word        (mem_rd),
    .wdata       (req_wdata),
    .size        (size),
    .offset      (req_addr[1:0]),
    .is_unsigned (req_funct3[2]),
    .merged      (lane_merged),
    .load_data   (lane_load)
  );

  always_comb begin
    state_d    = state_q;
    rmw_data_d = rmw_data_q;
    rmw_idx_d  = rmw_idx_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data;
    stall      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = req_wdata;
    w_idx      = idx;

    unique case (state_q)
      StIdle: begin
        if (active && !misaligned) begin
          if (ld_ok) begin
            mem_re     = 1'b1;
            ld_valid_d = 1'b1;
            ld_data_d  = lane_load;
          end else if (st_ok) begin
            if (size == SizeWord) begin
              mem_we = 1'b1;
            end else begin
              stall      = 1'b1;
              mem_re     = 1'b1;
              rmw_data_d = lane_merged;
              rmw_idx_d  = idx;
              state_d    = StRmwWr;
            end
          end
        end
      end
      StRmwWr: begin
        // The held SB/SH request is ignored here; its merged word is committed.
        mem_we  = rst_n;
        mem_wd  = rmw_data_q;
        w_idx   = rmw_idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_r_address = {{(32-WORD_ADDR_W){1'b0}}, idx};
  assign mem_w_address = {{(32-WORD_ADDR_W){1'b0}}, w_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rmw_data_q <= '0;
      rmw_idx_q  <= '0;
      ld_valid   <= 1'b0;
      ld_data    <= '0;
    end else begin
      state_q    <= state_d;
      rmw_data_q <= rmw_data_d;
      rmw_idx_q  <= rmw_idx_d;
      ld_valid   <= ld_valid_d;
      ld_data    <= ld_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory and a load scoreboard.
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, ld_valid, mem_re, mem_we;
  logic [31:0] ld_data, mem_r_address, mem_w_address, mem_wd, mem_rd;
`ifdef LSU_MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:7];
  logic [31:0] sb_q [$];
  int          n_checks = 0, n_errors = 0, wr_count = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
`ifdef LSU_MISALIGN_EXC_EN
    .misalign_exc  (misalign_exc),
`endif
    .mem_re        (mem_re),
    .mem_r_address (mem_r_address),
    .mem_we        (mem_we),
    .mem_w_address (mem_w_address),
    .mem_wd        (mem_wd),
    .mem_rd        (mem_rd)
  );

  assign mem_rd = mem[mem_r_address[9:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_w_address[9:0]] <= mem_wd;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every registered load result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && ld_valid) begin
      if (sb_q.size() == 0) check_eq("ld_unexpected", ld_data, 32'hxxxx_xxxx);
      else check_eq("ld_data", ld_data, sb_q.pop_front());
    end
    if (mem_re && mem_we) check_eq("re_we_overlap", mem_r_address, mem_w_address);
  end

  // Drives one request, holding it through any stall; returns #1 after its final edge.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int stalls, output logic we0,
                        output logic re0, output logic [31:0] wa0);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    stalls = 0;
    @(negedge clk);
    we0 = mem_we; re0 = mem_re; wa0 = mem_w_address;
    while (stall && stalls < 4) begin
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (int'(off) * 8));
    h = 16'(w >> (int'(off[1]) * 16));
    case (f3)
      LB:      return {{24{b[7]}}, b};
      LH:      return {{16{h[15]}}, h};
      LBU:     return {24'd0, b};
      LHU:     return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    if (f3 == SB) begin
      sh = int'(off) * 8;
      mask = 32'h0000_00FF << sh;
      return (w & ~mask) | ((d & 32'h0000_00FF) << sh);
    end else if (f3 == SH) begin
      sh = int'(off[1]) * 16;
      mask = 32'h0000_FFFF << sh;
      return (w & ~mask) | ((d & 32'h0000_FFFF) << sh);
    end
    return d;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st, w0, k, op;
    logic        we0, re0;
    logic [31:0] wa0;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic [31:0] d;

    // Reset with a sub-word store presented: nothing must leak out.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SB; req_addr = 32'h13;
    #13;
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_re", {31'd0, mem_re}, 32'd0);
    check_eq("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
    check_eq("rst_ld_data", ld_data, 32'd0);
    req_valid = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // SW then back-to-back LW.
    access(1'b1, SW, 32'h10, 32'hDEAD_BEEF, st, we0, re0, wa0);
    check_eq("sw_we_cycle0", {31'd0, we0}, 32'd1);
    check_eq("sw_no_stall", st, 0);
    sb_q.push_back(32'hDEAD_BEEF);
    access(1'b0, LW, 32'h10, 32'h0, st, we0, re0, wa0);
    check_eq("lw_latency1", {31'd0, ld_valid}, 32'd1);

    // SB into a known word, then immediate LW.
    access(1'b1, SW, 32'h10, 32'h1122_3344, st, we0, re0, wa0);
    w0 = wr_count;
    access(1'b1, SB, 32'h13, 32'h0000_00AA, st, we0, re0, wa0);
    check_eq("sb_stall_cycles", st, 1);
    check_eq("sb_write_count", wr_count - w0, 1);
    sb_q.push_back(32'hAA22_3344);
    access(1'b0, LW, 32'h10, 32'h0, st, we0, re0, wa0);

    // Sign/zero extension.
    access(1'b1, SW, 32'h10, 32'h8000_0000, st, we0, re0, wa0);
    sb_q.push_back(32'hFFFF_FF80);
    access(1'b0, LB, 32'h13, 32'h0, st, we0, re0, wa0);
    sb_q.push_back(32'h0000_0080);
    access(1'b0, LBU, 32'h13, 32'h0, st, we0, re0, wa0);
    sb_q.push_back(32'hFFFF_8000);
    access(1'b0, LH, 32'h12, 32'h0, st, we0, re0, wa0);
    sb_q.push_back(32'h0000_8000);
    access(1'b0, LHU, 32'h12, 32'h0, st, we0, re0, wa0);

    // SH interrupted by reset during the write cycle.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SH; req_addr = 32'h12; req_wdata = 32'hBEEF;
    @(negedge clk);
    check_eq("sh_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    w0 = wr_count;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check_eq("rst_rmw_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_rmw_writes", wr_count - w0, 0);
    sb_q.push_back(32'h8000_0000);
    access(1'b0, LW, 32'h10, 32'h0, st, we0, re0, wa0);

    // Misaligned word load.
`ifdef LSU_MISALIGN_EXC_EN
    access(1'b0, LW, 32'h11, 32'h0, st, we0, re0, wa0);
    check_eq("mis_no_re", {31'd0, re0}, 32'd0);
    check_eq("mis_no_we", {31'd0, we0}, 32'd0);
    check_eq("mis_exc", {31'd0, misalign_exc}, 32'd1);
    check_eq("mis_no_ld", {31'd0, ld_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("mis_exc_pulse", {31'd0, misalign_exc}, 32'd0);
`else
    sb_q.push_back(32'h8000_0000);
    access(1'b0, LW, 32'h11, 32'h0, st, we0, re0, wa0);
`endif

    // Address wrap.
    access(1'b1, SW, 32'h1000, 32'hCAFE_F00D, st, we0, re0, wa0);
    check_eq("wrap_waddr", wa0, 32'h0);
    sb_q.push_back(32'hCAFE_F00D);
    access(1'b0, LW, 32'h0, 32'h0, st, we0, re0, wa0);

    // Invalid funct3: no memory traffic, no load result.
    w0 = wr_count;
    access(1'b0, 3'b011, 32'h10, 32'h0, st, we0, re0, wa0);
    check_eq("bad_ld_no_re", {31'd0, re0}, 32'd0);
    access(1'b1, 3'b100, 32'h10, 32'h5555_5555, st, we0, re0, wa0);
    check_eq("bad_st_no_we", {31'd0, we0}, 32'd0);
    check_eq("bad_st_writes", wr_count - w0, 0);

    // Random aligned mix against a reference word model.
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      ref_mem[i] = d;
      access(1'b1, SW, 32'h200 + 32'(i * 4), d, st, we0, re0, wa0);
    end
    for (int i = 0; i < 60; i++) begin
      k  = int'($urandom_range(0, 7));
      op = int'($urandom_range(0, 7));
      d  = $urandom;
      off = 2'($urandom_range(0, 3));
      case (op)
        0: f3 = SB;
        1: begin f3 = SH; off[0] = 1'b0; end
        2: begin f3 = SW; off = 2'b00; end
        3: f3 = LB;
        4: f3 = LBU;
        5: begin f3 = LH; off[0] = 1'b0; end
        6: begin f3 = LHU; off[0] = 1'b0; end
        default: begin f3 = LW; off = 2'b00; end
      endcase
      if (op < 3) begin
        ref_mem[k] = ref_store(ref_mem[k], f3, off, d);
        access(1'b1, f3, 32'h200 + 32'(k * 4) + 32'(off), d, st, we0, re0, wa0);
      end else begin
        sb_q.push_back(ref_load(ref_mem[k], f3, off));
        access(1'b0, f3, 32'h200 + 32'(k * 4) + 32'(off), 32'h0, st, we0, re0, wa0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
